// File: rtl/ad7276_reader.sv
// ad7276_reader: free-running SPI master for the AD7276 12-bit ADC.
// One 16-SCLK conversion frame every PERIOD clk cycles; each 12-bit sample is
// presented on adc_data with a one-cycle adc_valid strobe.
// Ports:
//   clk           core clock (81.36 MHz)
//   rstn          asynchronous active-low reset
//   en            level-sensitive sampling enable
//   ad7276_csn    ADC chip select, active low
//   ad7276_sclk   ADC serial clock, idles high
//   ad7276_sdata  ADC serial data, MSB first
//   adc_valid     one-cycle strobe, new sample on adc_data
//   adc_data      12-bit unsigned sample, held until the next strobe
//   frame_err     leading/trailing-zero violation, qualified by adc_valid
// Optional feature: define AD7276_FRAME_CHECK_EN to enable the frame check;
// otherwise frame_err is tied low and only the 12 data bits are stored.
module ad7276_reader #(
    parameter int PERIOD = 36
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic        ad7276_csn,
    output logic        ad7276_sclk,
    input  logic        ad7276_sdata,
    output logic        adc_valid,
    output logic [11:0] adc_data,
    output logic        frame_err
);
    typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;

    localparam logic [9:0] K_LAST = 10'(PERIOD - 1);

    state_t      r_state, w_state_n;
    logic [9:0]  r_k, w_k_n;
    logic        r_sd_q;
    logic        r_csn;
    logic        r_sclk;
    logic        r_valid;
    logic [11:0] r_data;
    logic        w_shift;
    logic        w_done;

    // One counter spans the whole period: CONV is k = 0..31, QUIET is k = 32..PERIOD-1.
    always_comb begin
        w_state_n = r_state;
        w_k_n     = r_k + 10'd1;
        case (r_state)
            IDLE: begin
                w_k_n = '0;
                if (en) w_state_n = CONV;
            end
            CONV: if (r_k == 10'd31) w_state_n = QUIET;
            QUIET: if (r_k == K_LAST) begin
                w_k_n     = '0;
                w_state_n = en ? CONV : IDLE;
            end
            default: begin
                w_k_n     = '0;
                w_state_n = IDLE;
            end
        endcase
    end

    // A frame bit is taken from sd_q at the edge ending each odd CONV cycle.
    assign w_shift = (r_state == CONV) && r_k[0];
    assign w_done  = (r_state == CONV) && (r_k == 10'd31);

    // Pin outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_sd_q  <= 1'b0;
            r_csn   <= 1'b1;
            r_sclk  <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_k     <= w_k_n;
            r_sd_q  <= ad7276_sdata;
            r_csn   <= w_state_n != CONV;
            r_sclk  <= (w_state_n != CONV) | w_k_n[0];
            r_valid <= w_done;
        end
    end

`ifdef AD7276_FRAME_CHECK_EN
    logic [15:0] r_sr;
    logic        r_err;
    logic [15:0] w_frame;

    // Full frame b0..b15 including the bit arriving at the closing edge.
    assign w_frame = {r_sr[14:0], r_sd_q};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sr   <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_shift) r_sr <= w_frame;
            if (w_done) r_data <= w_frame[13:2];
            r_err <= w_done & (|{w_frame[15:14], w_frame[1:0]});
        end
    end

    assign frame_err = r_err;
`else
    logic [11:0] r_sr;

    // Only b2..b13 (k = 5..27) are kept; leading and trailing zeros are dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sr   <= '0;
            r_data <= '0;
        end else begin
            if (w_shift && r_k >= 10'd5 && r_k <= 10'd27) r_sr <= {r_sr[10:0], r_sd_q};
            if (w_done) r_data <= r_sr;
        end
    end

    assign frame_err = 1'b0;
`endif

    assign ad7276_csn  = r_csn;
    assign ad7276_sclk = r_sclk;
    assign adc_valid   = r_valid;
    assign adc_data    = r_data;
endmodule

// File: tb/tb_ad7276_reader.sv
// tb_ad7276_reader: two reader instances (PERIOD 36 and 34), each with an ADC
// model and a frame-timing reference model checked every cycle.
module tb_ad7276_reader;
`ifdef AD7276_FRAME_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic        clk = 1'b0;
    logic [1:0]  rstn = 2'b00;
    logic [1:0]  en = 2'b00;
    logic [1:0]  csn, sclk, sd, valid, err;
    logic [11:0] data [2];
    logic [15:0] tbl [2][8];
    int          tick = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    function automatic logic [15:0] mk(input logic [1:0] lead, input logic [11:0] d, input logic [1:0] trail);
        return {lead, d, trail};
    endfunction

    task automatic cmp(input string nm, input int l, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL lane%0d %s @tick %0d: got 0x%0h, expected 0x%0h", l, nm, tick, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int l, output int t);
        int n;
        n = 0;
        t = -1;
        while (t < 0 && n < 200) begin
            step();
            n++;
            if (valid[l]) t = tick;
        end
        if (t < 0) cmp("valid_timeout", l, 0, 1);
    endtask

    task automatic wait_csn(input int l);
        int n;
        n = 0;
        while (csn[l] && n < 200) begin
            step();
            n++;
        end
        if (csn[l]) cmp("csn_timeout", l, 1, 0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : ln
        localparam int P = g ? 34 : 36;

        ad7276_reader #(.PERIOD(P)) u_dut (
            .clk         (clk),
            .rstn        (rstn[g]),
            .en          (en[g]),
            .ad7276_csn  (csn[g]),
            .ad7276_sclk (sclk[g]),
            .ad7276_sdata(sd[g]),
            .adc_valid   (valid[g]),
            .adc_data    (data[g]),
            .frame_err   (err[g])
        );

        // ADC: on every SCLK fall inside a csn-low window present the next frame bit.
        int          bitn = 0;
        int          fi = 0;
        logic [15:0] cur = '0;
        initial begin
            sd[g] = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (csn[g]) begin
                    bitn = 0;
                    sd[g] = 1'b0;
                end else if (!sclk[g] && bitn < 16) begin
                    if (bitn == 0) begin
                        cur = tbl[g][fi % 8];
                        fi++;
                    end
                    sd[g] = cur[15 - bitn];
                    bitn++;
                end
            end
        end

        // Reference: a frame starts at cycle 'start' whenever en is seen once the
        // previous period has fully elapsed; everything follows from offset to it.
        int          cyc = 0;
        int          start = -100000;
        int          off;
        logic [11:0] e_data = '0;
        logic        e_csn, e_sclk, e_valid, e_err;
        initial forever begin
            @(posedge clk or negedge rstn[g]);
            if (!rstn[g]) begin
                start = -100000;
                e_data = '0;
            end else if (en[g] && cyc - start >= P - 1) start = cyc + 1;
            if (clk) cyc++;
        end

        initial forever begin
            @(negedge clk);
            off = cyc - start;
            e_csn = !(off >= 0 && off < 32);
            e_sclk = e_csn || (off % 2 == 1);
            e_valid = off == 32;
            if (e_valid) e_data = cur[13:2];
            e_err = e_valid && CHK == 1 && (cur[15] | cur[14] | cur[1] | cur[0]);
            cmp("csn", g, csn[g], e_csn);
            cmp("sclk", g, sclk[g], e_sclk);
            cmp("valid", g, valid[g], e_valid);
            cmp("data", g, data[g], e_data);
            cmp("err", g, err[g], e_err);
        end
    end

    task automatic lane0();
        int t0, t1, t2, t3, n, rises, bad;
        logic prev;
        repeat (3) step();
        cmp("rst_csn", 0, csn[0], 1);
        cmp("rst_sclk", 0, sclk[0], 1);
        cmp("rst_valid", 0, valid[0], 0);
        cmp("rst_data", 0, data[0], 0);
        cmp("rst_err", 0, err[0], 0);
        rstn[0] = 1'b1;
        bad = 0;
        repeat (200) begin
            step();
            if (!csn[0] || !sclk[0] || valid[0]) bad++;
        end
        cmp("idle_activity", 0, bad, 0);
        en[0] = 1'b1;
        t0 = tick;
        step();
        cmp("csn_fall_lat", 0, csn[0], 0);
        wait_valid(0, t1);
        cmp("first_valid_lat", 0, t1 - t0, 33);
        wait_valid(0, t2);
        cmp("period36_a", 0, t2 - t1, 36);
        wait_valid(0, t3);
        cmp("period36_b", 0, t3 - t2, 36);
        cmp("data_abc", 0, data[0], 12'hABC);
        wait_csn(0);
        n = 1;
        rises = 0;
        prev = sclk[0];
        while (!csn[0] && n < 100) begin
            step();
            if (!csn[0]) begin
                n++;
                if (!prev && sclk[0]) rises++;
                prev = sclk[0];
            end
        end
        cmp("csn_low_len", 0, n, 32);
        cmp("sclk_rises", 0, rises, 16);
        cmp("valid_after_window", 0, valid[0], 1);
        wait_valid(0, t1);
        wait_csn(0);
        repeat (10) step();
        en[0] = 1'b0;
        wait_valid(0, t1);
        cmp("data_5a5", 0, data[0], 12'h5A5);
        bad = 0;
        repeat (200) begin
            step();
            if (!csn[0] || valid[0]) bad++;
        end
        cmp("after_disable", 0, bad, 0);
        en[0] = 1'b1;
        wait_csn(0);
        repeat (20) step();
        rstn[0] = 1'b0;
        #1;
        cmp("async_csn", 0, csn[0], 1);
        cmp("async_sclk", 0, sclk[0], 1);
        step();
        cmp("abort_valid", 0, valid[0], 0);
        cmp("abort_data", 0, data[0], 0);
        rstn[0] = 1'b1;
        wait_valid(0, t1);
        cmp("data_3c3", 0, data[0], 12'h3C3);
        en[0] = 1'b0;
        repeat (40) step();
    endtask

    task automatic lane1();
        int t0, t1;
        repeat (3) step();
        rstn[1] = 1'b1;
        en[1] = 1'b1;
        wait_valid(1, t0);
        cmp("data_fff_a", 1, data[1], 12'hFFF);
        wait_valid(1, t1);
        cmp("period34_a", 1, t1 - t0, 34);
        cmp("data_000_a", 1, data[1], 12'h000);
        wait_valid(1, t0);
        cmp("period34_b", 1, t0 - t1, 34);
        cmp("data_fff_b", 1, data[1], 12'hFFF);
        wait_valid(1, t1);
        cmp("data_000_b", 1, data[1], 12'h000);
        wait_valid(1, t0);
        cmp("data_123", 1, data[1], 12'h123);
        cmp("err_123", 1, err[1], CHK);
        step();
        cmp("err_clears", 1, err[1], 0);
        wait_valid(1, t1);
        cmp("data_456", 1, data[1], 12'h456);
        cmp("err_456", 1, err[1], 0);
        en[1] = 1'b0;
        repeat (40) step();
    endtask

    initial begin
        tbl[0] = '{mk(2'b00, 12'h000, 2'b00), mk(2'b00, 12'h000, 2'b00), mk(2'b00, 12'hABC, 2'b00),
                   mk(2'b00, 12'h000, 2'b00), mk(2'b00, 12'h000, 2'b00), mk(2'b00, 12'h5A5, 2'b00),
                   mk(2'b00, 12'h777, 2'b00), mk(2'b00, 12'h3C3, 2'b00)};
        tbl[1] = '{mk(2'b00, 12'hFFF, 2'b00), mk(2'b00, 12'h000, 2'b00), mk(2'b00, 12'hFFF, 2'b00),
                   mk(2'b00, 12'h000, 2'b00), mk(2'b00, 12'h123, 2'b10), mk(2'b00, 12'h456, 2'b00),
                   mk(2'b00, 12'h000, 2'b00), mk(2'b00, 12'h000, 2'b00)};
        fork
            lane0();
            lane1();
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", fails);
        $fatal(1, "watchdog");
    end
endmodule
